// File: rtl/param_type_serializer.sv
// Serializes one value of packed type T into N_BEATS beats of BEAT_W bits.
// Build option: define PARAM_TYPE_SERIALIZER_MSB_FIRST_EN for most-significant-beat-first order.
module param_type_serializer #(
  parameter type         T       = bit [31:0],
  parameter int unsigned BEAT_W  = 8,
  localparam int unsigned N_BEATS = ($bits(T) + BEAT_W - 1) / BEAT_W,
  localparam type        CNT_T   = logic [$clog2(N_BEATS + 1)-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  T                  in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [BEAT_W-1:0] out_data_o,
  output logic              out_last_o
);

  localparam int unsigned TW = $bits(T);
  localparam int unsigned PW = N_BEATS * BEAT_W;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e        state_q;
  CNT_T          cnt_q;
  logic [PW-1:0] shift_q;
  logic [PW-1:0] load_val;
  logic [PW-1:0] shift_nxt;
  logic          out_valid_q;
  logic          out_last_q;

  always_comb begin
    load_val = '0;
    load_val[TW-1:0] = in_data_i;
`ifdef PARAM_TYPE_SERIALIZER_MSB_FIRST_EN
    // Left-align so padding lands in the low bits of the final beat.
    load_val  = load_val << (PW - TW);
    shift_nxt = shift_q << BEAT_W;
`else
    shift_nxt = shift_q >> BEAT_W;
`endif
  end

`ifdef PARAM_TYPE_SERIALIZER_MSB_FIRST_EN
  assign out_data_o = shift_q[PW-1 -: BEAT_W];
`else
  assign out_data_o = shift_q[BEAT_W-1:0];
`endif

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;

  // Accepting during the final beat's handshake gives zero-bubble back-to-back values.
  assign in_ready_o = (state_q == StIdle) ||
                      ((state_q == StSend) && out_ready_i && out_last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            state_q     <= StSend;
            shift_q     <= load_val;
            cnt_q       <= CNT_T'(N_BEATS - 1);
            out_valid_q <= 1'b1;
            out_last_q  <= (N_BEATS == 1);
          end
        end
        StSend: begin
          if (out_ready_i) begin
            if (cnt_q != '0) begin
              shift_q    <= shift_nxt;
              cnt_q      <= cnt_q - CNT_T'(1);
              out_last_q <= (cnt_q == CNT_T'(1));
            end else if (in_valid_i) begin
              shift_q     <= load_val;
              cnt_q       <= CNT_T'(N_BEATS - 1);
              out_valid_q <= 1'b1;
              out_last_q  <= (N_BEATS == 1);
            end else begin
              state_q     <= StIdle;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
